// File: rtl/clkmod_pkg.sv
// clkmod_pkg: FSM state type and reset divisor default shared by the clock modulator.
// CLKMOD_BURST_EN adds the BURST state.
package clkmod_pkg;

    localparam int unsigned CLKMOD_DIV_RST = 1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_RUN,
        ST_STOP
`ifdef CLKMOD_BURST_EN
        ,
        ST_BURST
`endif
    } state_t;

endpackage

// File: rtl/clkmod_half_cnt.sv
// clkmod_half_cnt: half-period counter with terminal-count compare against the active divisor.
module clkmod_half_cnt #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic [CNT_W-1:0] div,
    output logic             tc
);

    logic [CNT_W-1:0] cnt;

    assign tc = en && (cnt == div - CNT_W'(1));

    // Count while enabled, wrap at terminal count, hold at zero while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            cnt <= '0;
        else
            cnt <= (!en || tc) ? '0 : cnt + CNT_W'(1);
    end

endmodule

// File: rtl/clock_modulator_ctrl.sv
// clock_modulator_ctrl: run-gated 50% duty clock generator with a safely applied divisor update.
// Define CLKMOD_BURST_EN to add the fixed-length burst mode and its ports.
module clock_modulator_ctrl
    import clkmod_pkg::*;
#(
    parameter int          CNT_W   = 16,
    parameter int unsigned DIV_RST = CLKMOD_DIV_RST
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             run,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    output logic             out,
    output logic             tick,
    output logic             busy
`ifdef CLKMOD_BURST_EN
    ,
    input  logic             burst_start,
    input  logic [7:0]       burst_len,
    output logic             burst_done
`endif
);

    state_t           state;
    logic [CNT_W-1:0] div_act;
    logic [CNT_W-1:0] pend_div;
    logic [CNT_W-1:0] cfg_eff;
    logic [CNT_W-1:0] upd_div;
    logic             pend_valid;
    logic             tc;
    logic             acc;
    logic             upd;
    logic             period_end;
`ifdef CLKMOD_BURST_EN
    logic [7:0]       rem;
`endif

    assign busy       = (state != ST_IDLE);
    assign cfg_ready  = !pend_valid;
    assign acc        = cfg_valid && cfg_ready;
    assign cfg_eff    = (cfg_div == '0) ? CNT_W'(1) : cfg_div;
    // A full period ends at the terminal count of the low half
    assign period_end = tc && !out;
    assign upd        = pend_valid || acc;
    assign upd_div    = pend_valid ? pend_div : cfg_eff;

    clkmod_half_cnt #(.CNT_W(CNT_W)) u_half_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (busy),
        .div   (div_act),
        .tc    (tc)
    );

    // Divisor updates land directly while idle or at a period boundary, otherwise wait in the pending slot
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_act    <= CNT_W'(DIV_RST);
            pend_div   <= '0;
            pend_valid <= 1'b0;
        end else if (!busy || period_end) begin
            if (upd)
                div_act <= upd_div;
            pend_valid <= 1'b0;
        end else if (acc) begin
            pend_div   <= cfg_eff;
            pend_valid <= 1'b1;
        end
    end

    // Mode FSM driving the registered clock output and its rising-edge tick
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
            out   <= 1'b0;
            tick  <= 1'b0;
`ifdef CLKMOD_BURST_EN
            rem        <= 8'd0;
            burst_done <= 1'b0;
`endif
        end else begin
            tick <= 1'b0;
`ifdef CLKMOD_BURST_EN
            burst_done <= 1'b0;
`endif
            case (state)
                ST_IDLE: begin
`ifdef CLKMOD_BURST_EN
                    if (burst_start) begin
                        state <= ST_BURST;
                        rem   <= (burst_len == 8'd0) ? 8'd1 : burst_len;
                        out   <= 1'b1;
                        tick  <= 1'b1;
                    end else
`endif
                    if (run) begin
                        state <= ST_RUN;
                        out   <= 1'b1;
                        tick  <= 1'b1;
                    end
                end
                ST_RUN, ST_STOP: begin
                    if (period_end) begin
                        state <= run ? ST_RUN : ST_IDLE;
                        out   <= run;
                        tick  <= run;
                    end else begin
                        state <= run ? ST_RUN : ST_STOP;
                        if (tc)
                            out <= 1'b0;
                    end
                end
`ifdef CLKMOD_BURST_EN
                ST_BURST: begin
                    if (period_end) begin
                        if (rem == 8'd1) begin
                            state      <= ST_IDLE;
                            burst_done <= 1'b1;
                        end else begin
                            rem  <= rem - 8'd1;
                            out  <= 1'b1;
                            tick <= 1'b1;
                        end
                    end else if (tc) begin
                        out <= 1'b0;
                    end
                end
`endif
                default: begin
                    state <= ST_IDLE;
                    out   <= 1'b0;
                end
            endcase
        end
    end

endmodule
